// File: rtl/alu_serial.sv
// Digit-serial ALU: processes DIGIT bits per cycle, LSB-first, with valid/ready on both sides.
// Optional macro ALU_SERIAL_SIGNED_CMP_EN makes op 7 (SCMP) report a signed greater.
module alu_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             eq,
  output logic             greater,
  output logic             carry
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_XOR = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_eq;
  logic             r_gt;
  logic             r_carry;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic [DIGIT-1:0] w_db_op;
  logic [DIGIT-1:0] w_rd;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_res_top;
  logic             w_last;
  logic             w_gt_digit;
  logic             w_gt_next;

  // Operands are shifted right each cycle, so the current digit always sits at the bottom.
  assign w_da       = r_a[DIGIT-1:0];
  assign w_db       = r_b[DIGIT-1:0];
  assign w_last     = (r_cnt == LAST);
  assign w_db_op    = (r_op == OP_SUB) ? ~w_db : w_db;
  assign w_sum      = {1'b0, w_da} + {1'b0, w_db_op} + {{DIGIT{1'b0}}, r_carry};
  assign w_gt_digit = (w_da > w_db) | ((w_da == w_db) & r_gt);

`ifdef ALU_SERIAL_SIGNED_CMP_EN
  // On the sign digit, differing MSBs decide the signed order: b negative means a is greater.
  assign w_gt_next = ((r_op == 3'd7) && w_last && (w_da[DIGIT-1] != w_db[DIGIT-1]))
                     ? w_db[DIGIT-1] : w_gt_digit;
`else
  assign w_gt_next = w_gt_digit;
`endif

  always_comb begin
    w_rd = '0;
    case (r_op)
      OP_XOR:          w_rd = w_da ^ w_db;
      OP_OR:           w_rd = w_da | w_db;
      OP_AND:          w_rd = w_da & w_db;
      OP_NOT:          w_rd = ~w_da;
      OP_ADD, OP_SUB:  w_rd = w_sum[DIGIT-1:0];
      default:         w_rd = '0;
    endcase
  end

  assign w_res_top = WIDTH'(w_rd) << (WIDTH - DIGIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            r_eq    <= 1'b1;
            r_gt    <= 1'b0;
            r_carry <= (op == OP_SUB);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_res <= (r_res >> DIGIT) | w_res_top;
          r_eq  <= r_eq & (w_da == w_db);
          r_gt  <= w_gt_next;
          if ((r_op == OP_ADD) || (r_op == OP_SUB)) r_carry <= w_sum[DIGIT];
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_res;
  assign eq        = r_eq;
  assign greater   = r_gt;
  assign carry     = r_carry;

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: directed spot checks plus randomized ops against an arithmetic model.
module tb_alu_serial;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             eq, greater, carry;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .eq(eq),
    .greater(greater), .carry(carry)
  );

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b, res;
    logic             eq, gt, c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 1;  // 0 random, 1 always ready, 2 stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    logic [WIDTH:0] s;
    e.op = o; e.a = x; e.b = y; e.res = '0; e.c = 1'b0;
    e.eq = (x == y);
    e.gt = (x > y);
    case (o)
      3'd0: e.res = x ^ y;
      3'd1: e.res = x | y;
      3'd2: e.res = x & y;
      3'd3: e.res = ~x;
      3'd4: begin s = {1'b0, x} + {1'b0, y}; e.res = s[WIDTH-1:0]; e.c = s[WIDTH]; end
      3'd5: begin e.res = x - y; e.c = (x >= y); end
      default: e.res = '0;
    endcase
`ifdef ALU_SERIAL_SIGNED_CMP_EN
    if (o == 3'd7) e.gt = ($signed(x) > $signed(y));
`endif
    return e;
  endfunction

  // Output-side ready driver, updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: a transfer happens at the next rising edge when valid and ready are both high.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got result=%h with no expected entry", result);
      end else begin
        e = sb.pop_front();
        $display("txn op=%0d a=%h b=%h -> result=%h eq=%b gt=%b carry=%b", e.op, e.a, e.b, result, eq, greater, carry);
        check("result", 32'(result), 32'(e.res));
        check("eq", 32'(eq), 32'(e.eq));
        check("greater", 32'(greater), 32'(e.gt));
        check("carry", 32'(carry), 32'(e.c));
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    bit acc = 1'b0;
    int i = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!acc && i < 200) begin
      acc = in_ready;
      @(posedge clk);
      i++;
      if (!acc) @(negedge clk);
    end
    #1 in_valid = 1'b0;
    if (acc) sb.push_back(model(o, x, y));
    else check("issue_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (k < 50) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int k;
    logic [WIDTH-1:0] hold_res;
    logic hold_eq, hold_gt, hold_c;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, eq, greater, carry}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD with latency measurement from the accept edge
    rdy_mode = 1;
    issue(3'd4, 16'hFFFF, 16'h0001);
    wait_out(k);
    check("add_latency", 32'(k), 32'(N));
    check("add_result", 32'(result), 32'h0000);
    check("add_carry", 32'(carry), 32'd1);
    check("add_gt", 32'(greater), 32'd1);
    drain();

    issue(3'd5, 16'h0005, 16'h0007);
    issue(3'd6, 16'h1234, 16'h1234);
    issue(3'd6, 16'h2001, 16'h1FFF);
    issue(3'd3, 16'h00FF, 16'h00FF);
    drain();

    // Backpressure: result held while out_ready is low; new requests refused
    rdy_mode = 2;
    @(posedge clk);
    issue(3'd0, 16'hA5A5, 16'h0F0F);
    wait_out(k);
    check("bp_valid", 32'(out_valid), 32'd1);
    hold_res = result; hold_eq = eq; hold_gt = greater; hold_c = carry;
    op = 3'd4; a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_result", 32'(result), 32'(hold_res));
      check("bp_hold_flags", {29'd0, eq, greater, carry}, {29'd0, hold_eq, hold_gt, hold_c});
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    @(posedge clk);
    #2 check("bp_release_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2 check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    drain();

    // Reset in the second RUN cycle aborts the operation
    issue(3'd1, 16'h1111, 16'h2222);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", {29'd0, eq, greater, carry}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    issue(3'd0, 16'hF0F0, 16'hFF00);
    wait_out(k);
    check("xor_after_abort", 32'(result), 32'h0FF0);
    drain();

    // SCMP: signed order only when the option is compiled in
    issue(3'd7, 16'h8000, 16'h0001);
    wait_out(k);
`ifdef ALU_SERIAL_SIGNED_CMP_EN
    check("scmp_greater", 32'(greater), 32'd0);
`else
    check("scmp_greater", 32'(greater), 32'd1);
`endif
    check("scmp_result", 32'(result), 32'd0);
    drain();

    // Randomized ops with random consumer stalls
    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      logic [2:0] ro;
      logic [WIDTH-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      issue(ro, ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rdy_mode = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Multi-cycle, digit-serial ALU for WIDTH-bit operands.
- Processes DIGIT bits per clock, LSB-first, so one DIGIT-wide datapath handles any width.
- Carries compare state (eq/greater) and an add/sub carry from digit to digit.
- Adds arithmetic ops and a valid/ready handshake on both sides; sits between operand registers and the writeback stage of the core.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept a new operation.
- op  input  3  0 XOR, 1 OR, 2 AND, 3 NOT(a), 4 ADD, 5 SUB (a-b), 6 CMP, 7 SCMP.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  logic/arith result; 0 for CMP/SCMP.
- eq  output  1  a == b, valid for every op.
- greater  output  1  a > b; unsigned except SCMP with macro.
- carry  output  1  ADD carry-out / SUB no-borrow; 0 for other ops.

Behaviour:
- Reset is asynchronous and active-high, and aborts any operation.
  - State goes to IDLE.
  - in_ready=1 once rst deasserts; out_valid=0; result=0, eq=0, greater=0, carry=0; digit counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch a, b and op, then move to RUN.
  - At the same time: counter=0, eq_acc=1, gt_acc=0, carry_acc=(op==SUB).
- RUN (N=WIDTH/DIGIT cycles, in_ready=0). Each cycle k processes digit k = bits [k*DIGIT +: DIGIT]:
  - Logic ops: bitwise on the digit.
  - ADD: {c, s} = da + db + carry_acc.
  - SUB: {c, s} = da + ~db + carry_acc.
  - eq_acc &= (da == db).
  - gt_acc = (da > db) | ((da == db) & gt_acc). This is LSB-first, so a higher digit overrides lower ones.
  - The result digit is shifted into the top of the result shift register, right-shifting by DIGIT.
  - After digit N-1, move to DONE.
- DONE:
  - out_valid=1; result, eq, greater and carry are driven from the final state and held stable.
  - On out_ready, move to IDLE; in_ready rises the next cycle.
  - There is no overlap of consecutive operations.
- Latency and throughput:
  - If the accept edge is T, out_valid is high from edge T+N onward.
  - Minimum issue interval is N+2 cycles.
- Boundaries:
  - in_valid in RUN/DONE is ignored; the operands are not sampled.
  - out_ready while not in DONE has no effect.
  - DIGIT==WIDTH gives N=1.
  - Counter width is clog2(N), minimum 1.
  - ADD/SUB wrap modulo 2^WIDTH.
  - NOT ignores b for result, but eq/greater still compare a and b.
- Output fields are don't-care-stable when out_valid=0.
  - They must still come from registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ALU_SERIAL_SIGNED_CMP_EN.
- Defined: op 7 (SCMP) gives signed greater. It is computed as the unsigned gt_acc with the MSB relation inverted: if sign(a)!=sign(b), greater = sign(b). Final digit logic handles this. eq is unchanged.
- Undefined: op 7 behaves identically to op 6 (unsigned CMP); no extra logic.

Test Plan (WIDTH=16, DIGIT=4):
- ADD a=0xFFFF, b=0x0001, accept at edge T -> out_valid rises at edge T+4; result=0x0000, carry=1, eq=0, greater=1.
- SUB a=0x0005, b=0x0007 -> result=0xFFFE, carry=0, greater=0. Then CMP a=0x1234, b=0x1234 -> eq=1, greater=0, result=0.
- CMP a=0x2001, b=0x1FFF -> greater=1, eq=0; the high digit overrides the lower digits.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags stay stable, in_ready=0, a new in_valid is not accepted. out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Reset: assert rst in cycle 2 of RUN -> outputs go to 0 immediately, out_valid never asserts. A following XOR a=0xF0F0, b=0xFF00 completes with result=0x0FF0.
- SCMP a=0x8000, b=0x0001 -> greater=0 with ALU_SERIAL_SIGNED_CMP_EN, greater=1 without.
